// File: rtl/mux_arbitro_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_arbitro_pkg
// Desc     : Shared state encoding and default sizing for the mux arbiter.
// Revision : 1.0
// ============================================================================
package mux_arbitro_pkg;

   localparam int DATA_W_DEF    = 4;
   localparam int MAX_BURST_DEF = 4;
   localparam int CNT_W_DEF     = 16;

   // The grant output is the state value itself, so the encoding is one-hot.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_GNT_0 = 2'b01,
      ST_GNT_1 = 2'b10
   } state_t;

   // Burst counter width: enough to hold MAX_BURST-1, never narrower than 1.
   function automatic int burst_cnt_w(input int max_burst);
      return (max_burst > 1) ? $clog2(max_burst) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mux_arbitro_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : mux_arbitro_rr_pick
// Desc     : Combinational next-grant selection for the two-port arbiter.
// Revision : 1.0
// ============================================================================
module mux_arbitro_rr_pick
   import mux_arbitro_pkg::*;
(
   input  state_t state_i,
   input  logic   valid_0_i,
   input  logic   valid_1_i,
   input  logic   last_i,
   input  logic   burst_done_i,
   output state_t state_o
);

   always_comb begin
      state_o = state_i;
      case (state_i)
         ST_IDLE: begin
            // On a tie the port that was not served last wins.
            if (valid_0_i && valid_1_i) begin
               state_o = last_i ? ST_GNT_0 : ST_GNT_1;
            end else if (valid_0_i) begin
               state_o = ST_GNT_0;
            end else if (valid_1_i) begin
               state_o = ST_GNT_1;
            end else begin
               state_o = ST_IDLE;
            end
         end
         ST_GNT_0: begin
            if (!valid_0_i) begin
               state_o = valid_1_i ? ST_GNT_1 : ST_IDLE;
            end else if (burst_done_i && valid_1_i) begin
               state_o = ST_GNT_1;
            end
         end
         ST_GNT_1: begin
            if (!valid_1_i) begin
               state_o = valid_0_i ? ST_GNT_0 : ST_IDLE;
            end else if (burst_done_i && valid_0_i) begin
               state_o = ST_GNT_0;
            end
         end
         default: state_o = ST_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mux_arbitro.sv
`default_nettype none
// ============================================================================
// Module   : mux_arbitro
// Desc     : Two-port round-robin arbiter with burst limit and a one-word
//            registered output stage. Define MUX_ARBITRO_STATS_EN for counters.
// Revision : 1.0
// ============================================================================
module mux_arbitro
   import mux_arbitro_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
`ifdef MUX_ARBITRO_STATS_EN
  ,parameter int CNT_W     = CNT_W_DEF
`endif
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_0,
   input  logic [DATA_W-1:0] data_0,
   output logic              ready_0,
   input  logic              valid_1,
   input  logic [DATA_W-1:0] data_1,
   output logic              ready_1,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   input  logic              ready_out,
   output logic [1:0]        grant
`ifdef MUX_ARBITRO_STATS_EN
  ,output logic [CNT_W-1:0]  cnt_0,
   output logic [CNT_W-1:0]  cnt_1,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   localparam int              BC_W    = burst_cnt_w(MAX_BURST);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(MAX_BURST - 1);

   state_t            state_q, state_d;
   logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
   logic              last_q, last_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              valid_out_q, valid_out_d;

   logic              load_en;
   logic              in_xfer;
   logic              burst_done;
   logic [DATA_W-1:0] in_data;

   assign load_en    = !valid_out_q || ready_out;
   assign ready_0    = (state_q == ST_GNT_0) && load_en;
   assign ready_1    = (state_q == ST_GNT_1) && load_en;
   assign in_xfer    = (valid_0 && ready_0) || (valid_1 && ready_1);
   assign in_data    = (state_q == ST_GNT_1) ? data_1 : data_0;
   assign burst_done = in_xfer && (burst_cnt_q == BC_LAST);

   mux_arbitro_rr_pick u_rr_pick (
      .state_i      (state_q),
      .valid_0_i    (valid_0),
      .valid_1_i    (valid_1),
      .last_i       (last_q),
      .burst_done_i (burst_done),
      .state_o      (state_d)
   );

   // Leaving a grant state records who was served and restarts the burst.
   always_comb begin
      last_d      = last_q;
      burst_cnt_d = burst_cnt_q;
      if ((state_q != ST_IDLE) && (state_d != state_q)) begin
         last_d      = (state_q == ST_GNT_1);
         burst_cnt_d = '0;
      end else if (burst_done) begin
         burst_cnt_d = '0;
      end else if (in_xfer) begin
         burst_cnt_d = burst_cnt_q + 1'b1;
      end
   end

   always_comb begin
      data_out_d  = data_out_q;
      valid_out_d = valid_out_q;
      if (in_xfer) begin
         data_out_d  = in_data;
         valid_out_d = 1'b1;
      end else if (valid_out_q && ready_out) begin
         valid_out_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         burst_cnt_q <= '0;
         last_q      <= 1'b1;
         data_out_q  <= '0;
         valid_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         last_q      <= last_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
      end
   end

   assign grant     = state_q;
   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;

`ifdef MUX_ARBITRO_STATS_EN
   logic [CNT_W-1:0] cnt_0_q, cnt_0_d;
   logic [CNT_W-1:0] cnt_1_q, cnt_1_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // All three counters saturate at all-ones rather than wrapping.
   always_comb begin
      cnt_0_d     = cnt_0_q;
      cnt_1_d     = cnt_1_q;
      stall_cnt_d = stall_cnt_q;
      if (valid_0 && ready_0 && !(&cnt_0_q)) begin
         cnt_0_d = cnt_0_q + 1'b1;
      end
      if (valid_1 && ready_1 && !(&cnt_1_q)) begin
         cnt_1_d = cnt_1_q + 1'b1;
      end
      if (valid_out_q && !ready_out && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_0_q     <= '0;
         cnt_1_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         cnt_0_q     <= cnt_0_d;
         cnt_1_q     <= cnt_1_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign cnt_0     = cnt_0_q;
   assign cnt_1     = cnt_1_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_arbitro.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_arbitro
// Desc     : Self-checking bench for mux_arbitro against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_mux_arbitro;

   localparam int DW = 4;
   localparam int MB = 4;

   logic          clk;
   logic          rst;
   logic          v0, v1, ro;
   logic [DW-1:0] d0, d1;
   logic          ready_0, ready_1, valid_out;
   logic [DW-1:0] data_out;
   logic [1:0]    grant;
   logic [8:0]    act_vec;
`ifdef MUX_ARBITRO_STATS_EN
   logic [15:0]   cnt_0, cnt_1, stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   mux_arbitro #(
      .DATA_W    (DW),
      .MAX_BURST (MB)
   ) dut (
      .clk       (clk),
      .reset     (rst),
      .valid_0   (v0),
      .data_0    (d0),
      .ready_0   (ready_0),
      .valid_1   (v1),
      .data_1    (d1),
      .ready_1   (ready_1),
      .data_out  (data_out),
      .valid_out (valid_out),
      .ready_out (ro),
      .grant     (grant)
`ifdef MUX_ARBITRO_STATS_EN
     ,.cnt_0     (cnt_0),
      .cnt_1     (cnt_1),
      .stall_cnt (stall_cnt)
`endif
   );

   assign act_vec = {grant, ready_1, ready_0, valid_out, data_out};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transaction-level model: owner (-1 idle), words served in this burst,
   // last port served, and the one-word output slot.
   int          m_owner, m_run, m_last, m_xport;
   bit          m_xfer;
   logic        m_vout;
   logic [DW-1:0] m_dout;
   int          m_acc0, m_acc1, m_stall;

   function automatic logic [8:0] exp_vec();
      logic       load;
      logic [1:0] g;
      load = !m_vout || ro;
      g = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
      return {g, (m_owner == 1) && load, (m_owner == 0) && load, m_vout, m_dout};
   endfunction

   task automatic model_step();
      logic     load;
      bit [1:0] v;
      int       o, nxt;
      m_xfer = 0;
      if (rst) begin
         m_owner = -1; m_run = 0; m_last = 1; m_vout = 0; m_dout = '0;
         m_acc0 = 0; m_acc1 = 0; m_stall = 0;
         return;
      end
      v    = {v1, v0};
      load = !m_vout || ro;
      o    = m_owner;
      nxt  = o;
      if (m_vout && !ro) m_stall++;
      if (o < 0) begin
         if (v == 2'b11)  nxt = 1 - m_last;
         else if (v[0])   nxt = 0;
         else if (v[1])   nxt = 1;
      end else if (!v[o]) begin
         nxt    = v[1-o] ? 1 - o : -1;
         m_run  = 0;
         m_last = o;
      end else if (load) begin
         m_xfer  = 1;
         m_xport = o;
         m_run++;
         if (o == 0) m_acc0++; else m_acc1++;
         if (m_run == MB) begin
            m_run = 0;
            if (v[1-o]) begin
               nxt    = 1 - o;
               m_last = o;
            end
         end
      end
      if (m_xfer) begin
         m_vout = 1'b1;
         m_dout = (o == 0) ? d0 : d1;
      end else if (m_vout && ro) begin
         m_vout = 1'b0;
      end
      m_owner = nxt;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1; v0 = 1'b0; v1 = 1'b0; ro = 1'b0; d0 = '0; d1 = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      checks++;
      if (act_vec !== 9'b0) begin
         errors++;
         $display("FAIL reset_idle: got %b, want %b", act_vec, 9'b0);
      end
      v0 = 1'b1; d0 = 4'($urandom); v1 = 1'b1; d1 = 4'($urandom); ro = 1'b1;
      for (int c = 0; c < 7; c++) begin
         #1;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_traffic cyc %0d: got %b, want %b", c, act_vec, exp_vec());
         end
         tick();
         if (m_xfer) begin
            if (m_xport == 0) d0 = 4'($urandom); else d1 = 4'($urandom);
         end
      end
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (act_vec !== 9'b0) begin
         errors++;
         $display("FAIL reset_mid_traffic: got %b, want %b", act_vec, 9'b0);
      end
      tick();
      #1;
      checks++;
      if (grant !== 2'b01) begin
         errors++;
         $display("FAIL reset_first_tie: grant got %b, want 01", grant);
      end
   endtask

   task automatic test_single_port();
      apply_reset();
      v0 = 1'b1; d0 = 4'd1; ro = 1'b1;
      for (int c = 0; c < 12; c++) begin
         #1;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL single_model cyc %0d: got %b, want %b", c, act_vec, exp_vec());
         end
         if (c >= 1) begin
            checks++;
            if (grant !== 2'b01 || ready_1 !== 1'b0) begin
               errors++;
               $display("FAIL single_grant cyc %0d: grant %b ready_1 %b, want 01/0", c, grant, ready_1);
            end
         end
         if (c >= 2) begin
            checks++;
            if (valid_out !== 1'b1 || data_out !== 4'(c - 1)) begin
               errors++;
               $display("FAIL single_data cyc %0d: got %h/%b, want %h/1", c, data_out, valid_out, 4'(c - 1));
            end
         end
         tick();
         if (m_xfer) d0 = d0 + 1'b1;
      end
   endtask

   task automatic test_contention();
      logic [DW-1:0] want;
      apply_reset();
      v0 = 1'b1; d0 = 4'hA; v1 = 1'b1; d1 = 4'h5; ro = 1'b1;
      for (int c = 0; c < 20; c++) begin
         #1;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL contention_model cyc %0d: got %b, want %b", c, act_vec, exp_vec());
         end
         if (c >= 2) begin
            want = (((c - 2) / MB) % 2 == 0) ? 4'hA : 4'h5;
            checks++;
            if (valid_out !== 1'b1 || data_out !== want) begin
               errors++;
               $display("FAIL contention_seq cyc %0d: got %h/%b, want %h/1", c, data_out, valid_out, want);
            end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] nxt0;
      apply_reset();
      v0 = 1'b1; d0 = 4'd1; v1 = 1'b0; d1 = 4'h0; nxt0 = 4'd1;
      for (int c = 0; c < 16; c++) begin
         ro = !(c >= 4 && c <= 6);
         if (c == 8) v1 = 1'b1;
         #1;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL bp_model cyc %0d: got %b, want %b", c, act_vec, exp_vec());
         end
         if (c >= 4 && c <= 6) begin
            checks++;
            if (data_out !== 4'd3 || valid_out !== 1'b1 || ready_0 !== 1'b0) begin
               errors++;
               $display("FAIL bp_hold cyc %0d: data %h valid %b ready_0 %b, want 3/1/0",
                        c, data_out, valid_out, ready_0);
            end
         end
         if (valid_out === 1'b1 && ro && data_out !== 4'h0) begin
            checks++;
            if (data_out !== nxt0) begin
               errors++;
               $display("FAIL bp_order cyc %0d: got %h, want %h", c, data_out, nxt0);
            end
            nxt0 = nxt0 + 1'b1;
         end
         tick();
         if (m_xfer && m_xport == 0) d0 = d0 + 1'b1;
      end
   endtask

   task automatic test_early_release();
      // Port 1 waiting when port 0 drops: grant hands over directly.
      apply_reset();
      v0 = 1'b1; d0 = 4'd1; v1 = 1'b1; d1 = 4'h5; ro = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (c == 3) v0 = 1'b0;
         #1;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL release_model cyc %0d: got %b, want %b", c, act_vec, exp_vec());
         end
         if (c == 3 || c == 4) begin
            checks++;
            if (grant !== ((c == 3) ? 2'b01 : 2'b10)) begin
               errors++;
               $display("FAIL release_switch cyc %0d: grant got %b", c, grant);
            end
         end
         tick();
         if (m_xfer && m_xport == 0) d0 = d0 + 1'b1;
      end
      // Port 0 releases into IDLE; the following tie must favour port 1.
      apply_reset();
      v0 = 1'b1; d0 = 4'd1; ro = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (c == 3) v0 = 1'b0;
         if (c == 4) begin v0 = 1'b1; v1 = 1'b1; d1 = 4'h9; end
         #1;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL release_idle_model cyc %0d: got %b, want %b", c, act_vec, exp_vec());
         end
         if (c == 4 || c == 5) begin
            checks++;
            if (grant !== ((c == 4) ? 2'b00 : 2'b10)) begin
               errors++;
               $display("FAIL release_tie cyc %0d: grant got %b", c, grant);
            end
         end
         tick();
         if (m_xfer && m_xport == 0) d0 = d0 + 1'b1;
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         ro = ($urandom_range(0, 3) != 0);
         if (!v0 && $urandom_range(0, 1) == 1) begin v0 = 1'b1; d0 = 4'($urandom); end
         if (!v1 && $urandom_range(0, 1) == 1) begin v1 = 1'b1; d1 = 4'($urandom); end
         #1;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL random_model cyc %0d: got %b, want %b", c, act_vec, exp_vec());
         end
         tick();
         if (m_xfer) begin
            if (m_xport == 0) begin
               v0 = ($urandom_range(0, 3) != 0); d0 = 4'($urandom);
            end else begin
               v1 = ($urandom_range(0, 3) != 0); d1 = 4'($urandom);
            end
         end
      end
   endtask

`ifdef MUX_ARBITRO_STATS_EN
   task automatic test_stats();
      int acc0 = 0;
      int acc1 = 0;
      apply_reset();
      d0 = 4'd1; d1 = 4'd8;
      for (int c = 0; c < 30; c++) begin
         v0 = (acc0 < 10);
         v1 = (acc0 >= 10) && (acc1 < 6);
         ro = !(c >= 5 && c <= 7);
         #1;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL stats_model cyc %0d: got %b, want %b", c, act_vec, exp_vec());
         end
         tick();
         if (m_xfer) begin
            if (m_xport == 0) begin acc0++; d0 = d0 + 1'b1; end
            else begin acc1++; d1 = d1 + 1'b1; end
         end
      end
      checks++;
      if (cnt_0 !== 16'd10 || cnt_1 !== 16'd6 || stall_cnt !== 16'd3) begin
         errors++;
         $display("FAIL stats_counts: got %0d/%0d/%0d, want 10/6/3", cnt_0, cnt_1, stall_cnt);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; v0 = 1'b0; v1 = 1'b0; ro = 1'b0; d0 = '0; d1 = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_single_port();
      test_contention();
      test_backpressure();
      test_early_release();
      test_random();
`ifdef MUX_ARBITRO_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mux_arbitro.md
Name: mux_arbitro

Overview:
Round-robin arbiter that shares one 4-bit output channel (the mux datapath) between two requesters, port 0 and port 1, using valid/ready handshakes. A registered output stage holds one word. A burst limit bounds how long one port keeps the grant while the other is waiting. The block sits in front of the mux consumers and replaces free-running alternate selection with demand-driven scheduling.

Parameters:
DATA_W, 4, width of data_0/data_1/data_out
MAX_BURST, 4, max consecutive transfers granted to one port while the other port requests (≥1)
CNT_W, 16, width of statistics counters (optional feature only)

Ports:
clk  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
valid_0  input  1  port 0 has a word
data_0  input  DATA_W  port 0 word
ready_0  output  1  port 0 word accepted this cycle when valid_0 is also high
valid_1  input  1  port 1 has a word
data_1  input  DATA_W  port 1 word
ready_1  output  1  port 1 word accepted this cycle when valid_1 is also high
data_out  output  DATA_W  registered output word
valid_out  output  1  data_out holds a word
ready_out  input  1  downstream accepts data_out
grant  output  2  one-hot current grant; 00 in IDLE

Behaviour:
- Reset (reset=1 at a clk edge): state=IDLE, grant=00, data_out=0, valid_out=0, burst_cnt=0, last=1 (so port 0 wins the first tie). Any held word is discarded. ready_0/ready_1 are combinational and read 0 while in IDLE.
- load_en = !valid_out || ready_out. This gives full throughput: one word per cycle.
- ready_i = (state==GNT_i) && load_en. It never depends on valid_i.
- Input transfer on port i occurs when valid_i && ready_i. At the next edge, data_out<=data_i and valid_out<=1.
- Output transfer occurs when valid_out && ready_out. If no input transfer happens in the same cycle, valid_out<=0 and data_out keeps its last value.
- Latency: 1 cycle from input transfer to data_out.
- FSM states are IDLE, GNT_0 and GNT_1. The grant output equals the state encoding.
  - IDLE, both valid: go to GNT_(!last).
  - IDLE, one valid: go to that port.
  - IDLE, none valid: stay. A grant takes effect one cycle after the request.
  - GNT_i, on a transfer: burst_cnt++. Then:
    - burst_cnt reaches MAX_BURST-1 and valid_(!i)=1: go to GNT_(!i), burst_cnt<=0, last<=i.
    - burst_cnt reaches MAX_BURST-1 and valid_(!i)=0: stay in GNT_i, burst_cnt<=0.
  - GNT_i, valid_i=0: go to GNT_(!i) if valid_(!i), else IDLE. burst_cnt<=0 and last<=i.
  - GNT_i, valid_i=1 but load_en=0 (stall): hold state and burst_cnt. No switch while stalled.
- Both valids high with a continuous ready_out: ports alternate in bursts of exactly MAX_BURST words with no idle cycles between bursts.
- Only one port active: that port streams indefinitely at one word per cycle.
- Requesters must hold valid_i/data_i stable until accepted. The block does not check this.
- burst_cnt is wide enough to count to MAX_BURST-1. MAX_BURST=1 gives pure alternation.

Optional Feature:
MUX_ARBITRO_STATS_EN
- Defined: adds outputs cnt_0 and cnt_1 (CNT_W each) counting accepted input transfers per port, and stall_cnt (CNT_W) counting cycles with valid_out && !ready_out. All three clear on reset and saturate at all-ones.
- Undefined: these ports and registers are absent and the core behaviour is identical.

Decomposition:
- Shared package mux_arbitro_pkg holds:
  - state encodings ST_IDLE=2'b00, ST_GNT_0=2'b01, ST_GNT_1=2'b10;
  - DATA_W default;
  - MAX_BURST default.
- One sub-module, mux_arbitro_rr_pick: combinational next-grant selection from (state, valid_0, valid_1, last, burst_done).
- The output register and burst counter stay in the top module.

Test Plan:
- Reset: assert reset for 2 cycles during traffic -> next cycle valid_out=0, data_out=0, grant=00, ready_0=ready_1=0; first tie afterwards goes to port 0.
- Single port: valid_0=1 with data_0 stepping 1,2,3…; ready_out=1 -> grant=01 after 1 cycle, data_out=1,2,3… one per cycle; ready_1 never asserted.
- Contention, MAX_BURST=4: both valid with data_0=0xA and data_1=0x5 constant; ready_out=1 -> data_out sequence A,A,A,A,5,5,5,5,A… with no bubbles.
- Backpressure: single stream with ready_out low for 3 cycles mid-burst -> data_out/valid_out held, ready_i=0, burst_cnt frozen; no words lost or duplicated after release.
- Early release: port 0 drops valid after 2 words while port 1 is valid -> grant switches to 01→10 with last=0; next tie goes to port 1.
- Stats (MUX_ARBITRO_STATS_EN): 10 port-0 and 6 port-1 transfers plus 3 stall cycles -> cnt_0=10, cnt_1=6, stall_cnt=3.
